cae_csr_bank: RTL

Parametrised CSR register bank that sits on the csr_agent function interface (func_*) behind the management ring.
Generalises the single-register CAE CSR set to:
- N scratch registers
- a vector of sticky alarms with write-1-to-clear
- N saturating event counters
- an alarm interrupt output
All reads and writes are acknowledged with fixed one-cycle latency.

---
 rtl/cae_csr_bank.sv | 92 +++++++++
 1 files changed

// File: rtl/cae_csr_bank.sv
// cae_csr_bank: parametrised CSR bank (scratch, sticky W1C alarms, saturating counters, alarm irq); optional mask via CAE_CSR_ALARM_MASK_EN
module cae_csr_bank #(
  parameter int          NUM_SCRATCH = 4,
  parameter int          NUM_ALARM   = 8,
  parameter int          NUM_CNT     = 4,
  parameter int          CNT_W       = 48,
  parameter logic [63:0] BANK_ID     = 64'h0000_0000_0001_0000
) (
  input  logic                      clk_csr,
  input  logic                      i_csr_reset_n,
  input  logic                      func_wr_valid,
  input  logic                      func_rd_valid,
  input  logic [15:0]               func_address,
  input  logic [63:0]               func_wr_data,
  output logic                      func_ack,
  output logic [63:0]               func_rd_data,
  input  logic [63:0]               csr_status_in,
  input  logic [NUM_ALARM-1:0]      csr_alarm_in,
  input  logic [NUM_CNT-1:0]        cnt_inc,
  output logic [NUM_SCRATCH*64-1:0] csr_scratch_out,
  output logic                      csr_alarm_irq
);
  logic [63:0]          scratch [NUM_SCRATCH];
  logic [CNT_W-1:0]     cnt [NUM_CNT];
  logic [NUM_ALARM-1:0] sticky, sticky_nxt, mask, w1c;
  logic [63:0]          rd_val;
  assign w1c = (func_wr_valid && func_address == 16'h0002) ? func_wr_data[NUM_ALARM-1:0] : '0;
  assign sticky_nxt = (sticky & ~w1c) | csr_alarm_in;
  for (genvar g = 0; g < NUM_SCRATCH; g++) begin : g_out
    assign csr_scratch_out[64*g +: 64] = scratch[g];
  end
  // read mux over current (pre-write) state
  always_comb begin
    rd_val = '0;
    if (func_address == 16'h0000) rd_val = BANK_ID;
    if (func_address == 16'h0001) rd_val = csr_status_in;
    if (func_address == 16'h0002) rd_val = 64'(sticky);
    if (func_address == 16'h0003) rd_val = 64'(mask);
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (func_address == 16'(16 + i)) rd_val = scratch[i];
    for (int i = 0; i < NUM_CNT; i++)
      if (func_address == 16'(32 + i)) rd_val = 64'(cnt[i]);
  end
  // one-cycle ack; read data only for read requests
  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      func_ack     <= 1'b0;
      func_rd_data <= '0;
    end else begin
      func_ack     <= func_rd_valid | func_wr_valid;
      func_rd_data <= func_rd_valid ? rd_val : '0;
    end
  end
  // sticky alarms (set beats clear) and irq from next-state sticky
  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      sticky        <= '0;
      csr_alarm_irq <= 1'b0;
    end else begin
      sticky        <= sticky_nxt;
      csr_alarm_irq <= |(sticky_nxt & ~mask);
    end
  end
`ifdef CAE_CSR_ALARM_MASK_EN
  // alarm mask register, 1 = masked
  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) mask <= '0;
    else if (func_wr_valid && func_address == 16'h0003) mask <= func_wr_data[NUM_ALARM-1:0];
  end
`else
  assign mask = '0;
`endif
  // scratch registers
  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (func_wr_valid && func_address == 16'(16 + i)) scratch[i] <= func_wr_data;
    end
  end
  // saturating counters; a write beats an increment
  always_ff @(posedge clk_csr or negedge i_csr_reset_n) begin
    if (!i_csr_reset_n) begin
      for (int i = 0; i < NUM_CNT; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CNT; i++)
        if (func_wr_valid && func_address == 16'(32 + i)) cnt[i] <= func_wr_data[CNT_W-1:0];
        else if (cnt_inc[i] && cnt[i] != '1) cnt[i] <= cnt[i] + 1'b1;
    end
  end
endmodule
